axi_lite_slave_mem: RTL and testbench



---
 rtl/axi_lite_slave_mem.sv | 177 +++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_mem.sv
// axi_lite_slave_mem: AXI4-Lite register memory with byte strobes and SLVERR outside the window; AXI_MEM_UNALIGNED_ERR_EN also rejects misaligned addresses.
module axi_lite_slave_mem #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8,
   parameter int RESP_WIDTH = 3,
   parameter int DEPTH      = 4,
   parameter int BASE_ADDR  = 0
)(
   input  logic                    s_axi_aclk,
   input  logic                    s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                    s_axi_awvalid,
   output logic                    s_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
   input  logic                    s_axi_wvalid,
   output logic                    s_axi_wready,
   output logic [RESP_WIDTH-1:0]   s_axi_bresp,
   output logic                    s_axi_bvalid,
   input  logic                    s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                    s_axi_arvalid,
   output logic                    s_axi_arready,
   output logic [DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [RESP_WIDTH-1:0]   s_axi_rresp,
   output logic                    s_axi_rvalid,
   input  logic                    s_axi_rready
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam logic [RESP_WIDTH-1:0] SLVERR = RESP_WIDTH'(2);
   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_CAP, R_DATA} r_state_t;
   function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - ADDR_WIDTH'(BASE_ADDR);
`ifdef AXI_MEM_UNALIGNED_ERR_EN
      return a >= ADDR_WIDTH'(BASE_ADDR) && {1'b0, off} < (ADDR_WIDTH+1)'(DEPTH*4) && a[1:0] == 2'b00;
`else
      return a >= ADDR_WIDTH'(BASE_ADDR) && {1'b0, off} < (ADDR_WIDTH+1)'(DEPTH*4);
`endif
   endfunction
   function automatic logic [IW-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      logic [ADDR_WIDTH-1:0] off;
      off = a - ADDR_WIDTH'(BASE_ADDR);
      return off[IW+1:2];
   endfunction
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic unused_strb_msb;
   assign unused_strb_msb = s_axi_wstrb[NB];
   w_state_t w_state, w_state_nxt;
   logic aw_got, aw_got_nxt, w_got, w_got_nxt, commit;
   logic awready_nxt, wready_nxt, bvalid_nxt;
   logic [RESP_WIDTH-1:0] bresp_nxt;
   logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_nxt;
   logic [DATA_WIDTH-1:0] w_data, w_data_nxt;
   logic [NB-1:0] w_strb, w_strb_nxt;
   always_comb begin
      w_state_nxt = w_state;
      aw_got_nxt  = aw_got;
      w_got_nxt   = w_got;
      aw_addr_nxt = aw_addr;
      w_data_nxt  = w_data;
      w_strb_nxt  = w_strb;
      awready_nxt = s_axi_awready;
      wready_nxt  = s_axi_wready;
      bvalid_nxt  = s_axi_bvalid;
      bresp_nxt   = s_axi_bresp;
      commit      = 1'b0;
      if (w_state == W_IDLE) begin
         if (s_axi_awvalid && s_axi_awready) begin
            aw_got_nxt  = 1'b1;
            aw_addr_nxt = s_axi_awaddr;
         end
         if (s_axi_wvalid && s_axi_wready) begin
            w_got_nxt  = 1'b1;
            w_data_nxt = s_axi_wdata;
            w_strb_nxt = s_axi_wstrb[NB-1:0];
         end
         awready_nxt = !aw_got_nxt;
         wready_nxt  = !w_got_nxt;
         if (aw_got && w_got) begin
            commit      = addr_ok(aw_addr);
            bvalid_nxt  = 1'b1;
            bresp_nxt   = addr_ok(aw_addr) ? '0 : SLVERR;
            w_state_nxt = W_RESP;
         end
      end else if (s_axi_bready) begin
         bvalid_nxt  = 1'b0;
         awready_nxt = 1'b1;
         wready_nxt  = 1'b1;
         aw_got_nxt  = 1'b0;
         w_got_nxt   = 1'b0;
         w_state_nxt = W_IDLE;
      end
   end
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         w_state       <= W_IDLE;
         aw_got        <= 1'b0;
         w_got         <= 1'b0;
         aw_addr       <= '0;
         w_data        <= '0;
         w_strb        <= '0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= '0;
      end else begin
         w_state       <= w_state_nxt;
         aw_got        <= aw_got_nxt;
         w_got         <= w_got_nxt;
         aw_addr       <= aw_addr_nxt;
         w_data        <= w_data_nxt;
         w_strb        <= w_strb_nxt;
         s_axi_awready <= awready_nxt;
         s_axi_wready  <= wready_nxt;
         s_axi_bvalid  <= bvalid_nxt;
         s_axi_bresp   <= bresp_nxt;
      end
   end
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
      end else if (commit) begin
         for (int b = 0; b < NB; b++)
            if (w_strb[b]) mem[addr_idx(aw_addr)][8*b +: 8] <= w_data[8*b +: 8];
      end
   end
   r_state_t r_state, r_state_nxt;
   logic [ADDR_WIDTH-1:0] ar_addr, ar_addr_nxt;
   logic arready_nxt, rvalid_nxt;
   logic [DATA_WIDTH-1:0] rdata_nxt;
   logic [RESP_WIDTH-1:0] rresp_nxt;
   always_comb begin
      r_state_nxt = r_state;
      ar_addr_nxt = ar_addr;
      arready_nxt = s_axi_arready;
      rvalid_nxt  = s_axi_rvalid;
      rdata_nxt   = s_axi_rdata;
      rresp_nxt   = s_axi_rresp;
      if (r_state == R_IDLE) begin
         arready_nxt = 1'b1;
         if (s_axi_arvalid && s_axi_arready) begin
            ar_addr_nxt = s_axi_araddr;
            arready_nxt = 1'b0;
            r_state_nxt = R_CAP;
         end
      end else if (r_state == R_CAP) begin
         rvalid_nxt  = 1'b1;
         rdata_nxt   = addr_ok(ar_addr) ? mem[addr_idx(ar_addr)] : '0;
         rresp_nxt   = addr_ok(ar_addr) ? '0 : SLVERR;
         r_state_nxt = R_DATA;
      end else if (s_axi_rready) begin
         rvalid_nxt  = 1'b0;
         arready_nxt = 1'b1;
         r_state_nxt = R_IDLE;
      end
   end
   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         r_state       <= R_IDLE;
         ar_addr       <= '0;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= '0;
         s_axi_rresp   <= '0;
      end else begin
         r_state       <= r_state_nxt;
         ar_addr       <= ar_addr_nxt;
         s_axi_arready <= arready_nxt;
         s_axi_rvalid  <= rvalid_nxt;
         s_axi_rdata   <= rdata_nxt;
         s_axi_rresp   <= rresp_nxt;
      end
   end
endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// tb_axi_lite_slave_mem: directed checks of two memories, window at 0 (sel 0) and at 16 (sel 1).
module tb_axi_lite_slave_mem;
   logic clk = 1'b0, aresetn = 1'b0, sel = 1'b0;
   logic [7:0] awaddr = '0, araddr = '0;
   logic [31:0] wdata = '0;
   logic [4:0] wstrb = '0;
   logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
   logic awready [2], wready [2], bvalid [2], arready [2], rvalid [2];
   logic [2:0] bresp [2], rresp [2];
   logic [31:0] rdata [2];
   int n_vec = 0, n_bad = 0;
`ifdef AXI_MEM_UNALIGNED_ERR_EN
   localparam bit UNAL = 1'b1;
`else
   localparam bit UNAL = 1'b0;
`endif
   always #5 clk = ~clk;
   axi_lite_slave_mem #(.BASE_ADDR(0)) dut0 (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && sel == 1'b0), .s_axi_awready(awready[0]),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && sel == 1'b0), .s_axi_wready(wready[0]),
      .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && sel == 1'b0), .s_axi_arready(arready[0]),
      .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready));
   axi_lite_slave_mem #(.BASE_ADDR(16)) dut1 (
      .s_axi_aclk(clk), .s_axi_aresetn(aresetn),
      .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid && sel == 1'b1), .s_axi_awready(awready[1]),
      .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid && sel == 1'b1), .s_axi_wready(wready[1]),
      .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready),
      .s_axi_araddr(araddr), .s_axi_arvalid(arvalid && sel == 1'b1), .s_axi_arready(arready[1]),
      .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready));
   typedef struct {
      bit wr;
      bit s;
      logic [7:0] a;
      logic [31:0] d;
      logic [4:0] st;
      logic [2:0] resp;
   } vec_t;
   vec_t vt [$];
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   task automatic wr(input bit s, input logic [7:0] a, input logic [31:0] d, input logic [4:0] st, input logic [2:0] er);
      sel = s; awaddr = a; awvalid = 1'b1; wdata = d; wstrb = st; wvalid = 1'b1; bready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_ready_drop", {awready[s], wready[s], bvalid[s]}, 3'b000);
      tick();
      chk("wr_bvalid", bvalid[s], 1'b1);
      chk("wr_bresp", bresp[s], er);
      tick();
      chk("wr_b_done", {bvalid[s], awready[s], wready[s]}, 3'b011);
   endtask
   task automatic rd(input bit s, input logic [7:0] a, input logic [31:0] ed, input logic [2:0] er);
      sel = s; araddr = a; arvalid = 1'b1; rready = 1'b1;
      tick();
      arvalid = 1'b0;
      chk("rd_ready_drop", {arready[s], rvalid[s]}, 2'b00);
      tick();
      chk("rd_rvalid", rvalid[s], 1'b1);
      chk("rd_rdata", rdata[s], ed);
      chk("rd_rresp", rresp[s], er);
      tick();
      chk("rd_r_done", {rvalid[s], arready[s]}, 2'b01);
   endtask
   initial begin
      vt.push_back('{1'b1, 1'b0, 8'd8,  32'h00000038, 5'h0F, 3'd0});
      vt.push_back('{1'b0, 1'b0, 8'd8,  32'h00000038, 5'h00, 3'd0});
      vt.push_back('{1'b1, 1'b0, 8'd4,  32'h11223344, 5'h0F, 3'd0});
      vt.push_back('{1'b1, 1'b0, 8'd4,  32'hAABBCCDD, 5'h02, 3'd0});
      vt.push_back('{1'b0, 1'b0, 8'd4,  32'h1122CC44, 5'h00, 3'd0});
      vt.push_back('{1'b1, 1'b0, 8'd4,  32'hFFFFFFFF, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b0, 8'd4,  32'h1122CC44, 5'h00, 3'd0});
      vt.push_back('{1'b1, 1'b0, 8'd16, 32'hDEADBEEF, 5'h0F, 3'd2});
      vt.push_back('{1'b0, 1'b0, 8'd16, 32'h00000000, 5'h00, 3'd2});
      vt.push_back('{1'b1, 1'b0, 8'd0,  32'h12345678, 5'h1F, 3'd0});
      vt.push_back('{1'b0, 1'b0, 8'd0,  32'h12345678, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b0, 8'd8,  32'h00000038, 5'h00, 3'd0});
      vt.push_back('{1'b1, 1'b1, 8'd4,  32'hCAFEF00D, 5'h0F, 3'd2});
      vt.push_back('{1'b1, 1'b1, 8'd24, 32'h0000004C, 5'h0F, 3'd0});
      vt.push_back('{1'b0, 1'b1, 8'd24, 32'h0000004C, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b1, 8'd40, 32'h00000000, 5'h00, 3'd2});
      vt.push_back('{1'b0, 1'b1, 8'd16, 32'h00000000, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b1, 8'd20, 32'h00000000, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b1, 8'd28, 32'h00000000, 5'h00, 3'd0});
      vt.push_back('{1'b0, 1'b1, 8'd32, 32'h00000000, 5'h00, 3'd2});
      vt.push_back('{1'b0, 1'b1, 8'd12, 32'h00000000, 5'h00, 3'd2});
      tick();
      tick();
      chk("rst_ctrl", {awready[0], wready[0], arready[0], bvalid[0], rvalid[0], bresp[0], rresp[0]}, 11'd0);
      chk("rst_rdata", rdata[0], 32'h0);
      aresetn = 1'b1;
      tick();
      chk("rst_release_ready", {awready[0], wready[0], arready[0], awready[1], wready[1], arready[1]}, 6'h3F);
      foreach (vt[i]) begin
         if (vt[i].wr) wr(vt[i].s, vt[i].a, vt[i].d, vt[i].st, vt[i].resp);
         else rd(vt[i].s, vt[i].a, vt[i].d, vt[i].resp);
      end
      sel = 1'b0; bready = 1'b0; awaddr = 8'd12; wdata = 32'h0000004C; wstrb = 5'h0F; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("w_first_ready", {wready[0], awready[0]}, 2'b01);
      tick();
      tick();
      chk("w_first_wait", {wready[0], bvalid[0]}, 2'b00);
      awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("aw_late_ready", {awready[0], bvalid[0]}, 2'b00);
      tick();
      chk("aw_late_bvalid", {bvalid[0], bresp[0]}, 4'b1000);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("b_backpressure", {bvalid[0], bresp[0], awready[0], wready[0]}, 6'b100000);
      end
      bready = 1'b1;
      tick();
      chk("b_release", {bvalid[0], awready[0], wready[0]}, 3'b011);
      rd(1'b0, 8'd12, 32'h0000004C, 3'd0);
      araddr = 8'd4; arvalid = 1'b1; rready = 1'b0;
      tick();
      arvalid = 1'b0;
      tick();
      chk("r_bp_first", {rvalid[0], rresp[0]}, 4'b1000);
      chk("r_bp_first_data", rdata[0], 32'h1122CC44);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("r_backpressure", {rvalid[0], arready[0]}, 2'b10);
         chk("r_bp_data", rdata[0], 32'h1122CC44);
      end
      rready = 1'b1;
      tick();
      chk("r_release", {rvalid[0], arready[0]}, 2'b01);
      awaddr = 8'd0; wdata = 32'hA5A5A5A5; wstrb = 5'h0F; araddr = 8'd0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      tick();
      chk("race_valids", {bvalid[0], rvalid[0]}, 2'b11);
      chk("race_old_data", rdata[0], 32'h12345678);
      tick();
      rd(1'b0, 8'd0, 32'hA5A5A5A5, 3'd0);
      awaddr = 8'd0; awvalid = 1'b1;
      tick();
      awvalid = 1'b0; aresetn = 1'b0;
      tick();
      chk("abort_ctrl", {awready[0], wready[0], arready[0], bvalid[0], rvalid[0], bresp[0], rresp[0]}, 11'd0);
      chk("abort_rdata", rdata[0], 32'h0);
      aresetn = 1'b1;
      tick();
      chk("abort_release", {awready[0], wready[0], arready[0], bvalid[0]}, 4'b1110);
      tick();
      chk("abort_no_bvalid", bvalid[0], 1'b0);
      rd(1'b0, 8'd0, 32'h0, 3'd0);
      wr(1'b0, 8'd0, 32'h00000077, 5'h0F, 3'd0);
      rd(1'b0, 8'd2, UNAL ? 32'h0 : 32'h00000077, UNAL ? 3'd2 : 3'd0);
      wr(1'b0, 8'd6, 32'h00000099, 5'h0F, UNAL ? 3'd2 : 3'd0);
      rd(1'b0, 8'd4, UNAL ? 32'h0 : 32'h00000099, 3'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
